// File: rtl/gactx_tile_drain_if.sv
// rtl/gactx_tile_drain_if.sv - result header and traceback direction streams of the tile drain
//
// Purpose: bundles the two ready/valid output streams of gactx_tile_drain.
// Signals:
//   hdr_valid/hdr_ready/hdr_data[127:0]              result header stream
//   dir_valid/dir_ready/dir_data[DIR_WIDTH-1:0]/dir_last  direction stream
// Modports: master = drain side (drives valid/data/last), slave = consumer side.

interface gactx_tile_drain_if #(
    parameter int DIR_WIDTH = 128
);
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [127:0]         hdr_data;
    logic                 dir_valid;
    logic                 dir_ready;
    logic [DIR_WIDTH-1:0] dir_data;
    logic                 dir_last;

    modport master (
        output hdr_valid, hdr_data, dir_valid, dir_data, dir_last,
        input  hdr_ready, dir_ready
    );

    modport slave (
        input  hdr_valid, hdr_data, dir_valid, dir_data, dir_last,
        output hdr_ready, dir_ready
    );
endinterface

// File: rtl/gactx_tile_drain.sv
// rtl/gactx_tile_drain.sv - drains one alignment tile: result header then traceback direction words
//
// Purpose: after a tile is launched, waits for the array to finish, emits a
// 128-bit header, then reads arr_dir_count direction words from the BRAM and
// streams them out, one read in flight at a time.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             arm a drain / discard the current tile
//   arr_done, arr_*          array completion pulse and the results it qualifies
//   dir_rd_addr, dir_rd_data direction BRAM read port (RD_LAT cycles addr to data)
//   strm                     header and direction streams (master modport)
//   busy, tile_cnt           not-idle flag, count of completed drains

module gactx_tile_drain #(
    parameter int PE_WIDTH          = 25,
    parameter int LOG_MAX_TILE_SIZE = 13,
    parameter int DIR_WIDTH         = 128,
    parameter int DIR_ADDR_WIDTH    = 8,
    parameter int RD_LAT            = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         arr_done,
    input  logic signed [PE_WIDTH-1:0]   arr_score,
    input  logic [LOG_MAX_TILE_SIZE-1:0] arr_ref_max_pos,
    input  logic [LOG_MAX_TILE_SIZE-1:0] arr_query_max_pos,
    input  logic [DIR_ADDR_WIDTH:0]      arr_dir_count,
    output logic [DIR_ADDR_WIDTH-1:0]    dir_rd_addr,
    input  logic [DIR_WIDTH-1:0]         dir_rd_data,
    gactx_tile_drain_if.master           strm,
    output logic                         busy,
    output logic [31:0]                  tile_cnt
);

    localparam int AW = DIR_ADDR_WIDTH;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
    localparam logic [1:0]  LAT_INIT   = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DONE, S_HDR, S_RD_ISSUE, S_RD_WAIT, S_DIR_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [AW:0]          cnt_q;
    logic [1:0]           lat_q;
    logic [127:0]         hdr_data_q;
    logic [DIR_WIDTH-1:0] dir_data_q;
    logic [AW-1:0]        addr_q;
    logic [31:0]          tile_cnt_q;

    logic        hdr_valid, dir_valid, dir_last;
    logic        hdr_fire, dir_fire, is_last, capture;
    logic [AW:0] cnt_in;

    // A transfer that coincides with abort is discarded.
    assign hdr_fire = (state_q == S_HDR) && strm.hdr_ready && !abort;
    assign dir_fire = (state_q == S_DIR_OUT) && strm.dir_ready && !abort;
    assign capture  = (state_q == S_WAIT_DONE) && arr_done && !abort;
    assign is_last  = ({1'b0, addr_q} == (cnt_q - 1'b1));
    assign cnt_in   = (arr_dir_count > FULL_COUNT) ? FULL_COUNT : arr_dir_count;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (start)    state_d = S_WAIT_DONE;
                S_WAIT_DONE: if (arr_done) state_d = S_HDR;
                S_HDR:       if (strm.hdr_ready)
                                 state_d = (cnt_q == '0) ? S_IDLE : S_RD_ISSUE;
                S_RD_ISSUE:  state_d = S_RD_WAIT;
                S_RD_WAIT:   if (lat_q == 2'd0) state_d = S_DIR_OUT;
                S_DIR_OUT:   if (strm.dir_ready)
                                 state_d = is_last ? S_IDLE : S_RD_ISSUE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        hdr_valid = (state_q == S_HDR);
        dir_valid = (state_q == S_DIR_OUT);
        dir_last  = dir_valid && is_last;
        busy      = (state_q != S_IDLE);
    end

    // Datapath. The read address only moves on a header or direction
    // transfer, so it stays put from RD_ISSUE until the beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            lat_q      <= '0;
            hdr_data_q <= '0;
            dir_data_q <= '0;
            addr_q     <= '0;
            tile_cnt_q <= '0;
        end else begin
            if (capture) begin
                cnt_q      <= cnt_in;
                hdr_data_q <= {32'(cnt_in), 32'(arr_query_max_pos),
                               32'(arr_ref_max_pos), 32'(arr_score)};
            end
            if (hdr_fire)
                addr_q <= '0;
            else if (dir_fire && !is_last)
                addr_q <= addr_q + 1'b1;
            if (state_q == S_RD_ISSUE)
                lat_q <= LAT_INIT;
            else if ((state_q == S_RD_WAIT) && (lat_q != 2'd0))
                lat_q <= lat_q - 2'd1;
            if ((state_q == S_RD_WAIT) && (lat_q == 2'd0) && !abort)
                dir_data_q <= dir_rd_data;
            if ((hdr_fire && (cnt_q == '0)) || (dir_fire && is_last))
                tile_cnt_q <= tile_cnt_q + 32'd1;
        end
    end

    assign dir_rd_addr    = addr_q;
    assign tile_cnt       = tile_cnt_q;
    assign strm.hdr_valid = hdr_valid;
    assign strm.hdr_data  = hdr_data_q;
    assign strm.dir_valid = dir_valid;
    assign strm.dir_data  = dir_data_q;
    assign strm.dir_last  = dir_last;

endmodule
